ef_smsdac8_seq: RTL and testbench

Sample-rate sequencer for the 8-bit segmented mismatch-shaping DAC. It accepts host samples through a valid/ready handshake into a small FIFO and paces them out at a programmable oversampling ratio. It soft-ramps the DAC code between mid-scale and live data to suppress start/stop pops, and drives the encoder and dither enables. It sits between the host interface and the DAC core's `i_x`, `i_en_enc` and `i_en_dith` inputs.

---
 rtl/ef_smsdac8_seq.sv | 216 +++++++++++++++++++++
 tb/tb_ef_smsdac8_seq.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ef_smsdac8_seq.sv
// ef_smsdac8_seq: sample-rate sequencer for the 8-bit segmented mismatch-shaping DAC.
// Buffers host samples, paces them at one per i_osr+1 cycles and soft-ramps to/from mid-scale.
module ef_smsdac8_seq #(
  parameter int DEPTH = 4,
  parameter int OSR_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [OSR_W-1:0] i_osr,
  input  logic             i_valid,
  input  logic [7:0]       i_data,
  output logic             o_ready,
  input  logic             i_mute,
  input  logic             i_dith_cfg,
  output logic [7:0]       o_x,
  output logic             o_en_enc,
  output logic             o_en_dith,
  output logic             o_strobe,
  output logic             o_underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0]       MID      = 8'h80;
  localparam logic [AW:0]      PTR_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]      PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]      FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [OSR_W-1:0] CNT_ZERO = {OSR_W{1'b0}};
  localparam logic [OSR_W-1:0] CNT_ONE  = {{(OSR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUP   = 2'd1,
    RUN   = 2'd2,
    RDOWN = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [OSR_W-1:0] cnt_r;
  logic             tick_s;
  logic [7:0]       mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [AW:0]      level_s;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic             flush_s;
  logic [7:0]       head_s;
  logic [7:0]       x_r;
  logic             en_enc_r;
  logic             en_dith_r;
  logic             strobe_r;
  logic             underrun_r;

  // One LSB toward the target; the unsigned compare means 8'h00/8'hFF never wrap.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    logic [7:0] res;
    if (cur < tgt) begin
      res = cur + 8'd1;
    end else if (cur > tgt) begin
      res = cur - 8'd1;
    end else begin
      res = cur;
    end
    return res;
  endfunction

  assign tick_s  = (cnt_r >= i_osr);
  assign level_s = wr_ptr_r - rd_ptr_r;
  assign full_s  = (level_s == FULL_LVL);
  assign empty_s = (level_s == PTR_ZERO);
  assign head_s  = mem_r[rd_ptr_r[AW-1:0]];
  assign o_ready = ~full_s & (state_r != RDOWN);
  assign push_s  = i_valid & o_ready;

  assign o_x        = x_r;
  assign o_en_enc   = en_enc_r;
  assign o_en_dith  = en_dith_r;
  assign o_strobe   = strobe_r;
  assign o_underrun = underrun_r;

  // Free-running prescaler; >= tolerates i_osr being lowered mid-count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_r <= CNT_ZERO;
    end else if (tick_s) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // FIFO storage; contents are don't-care while the pointers mark it empty.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= i_data;
    end
  end

  // FIFO pointers; the end of a ramp-down discards anything still queued.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else if (flush_s) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Next-state, pop and flush decode; everything advances only on a tick.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    flush_s     = 1'b0;
    if (tick_s) begin
      case (state_r)
        IDLE: begin
          if (!i_mute && !empty_s) begin
            state_nxt_s = RUP;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        RUP: begin
          if (i_mute) begin
            state_nxt_s = RDOWN;
          end else if (!empty_s && (x_r == head_s)) begin
            pop_s       = 1'b1;
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = RUP;
          end
        end
        RUN: begin
          if (i_mute) begin
            state_nxt_s = RDOWN;
          end else if (!empty_s) begin
            pop_s       = 1'b1;
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = RUN;
          end
        end
        RDOWN: begin
          if (x_r == MID) begin
            flush_s     = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = RDOWN;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Sequencer state and all registered DAC-side outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r    <= IDLE;
      x_r        <= MID;
      en_enc_r   <= 1'b0;
      en_dith_r  <= 1'b0;
      strobe_r   <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      en_dith_r  <= i_dith_cfg & (state_nxt_s == RUN);
      strobe_r   <= tick_s & (state_r != IDLE);
      underrun_r <= tick_s & (state_r == RUN) & ~i_mute & empty_s;
      if (tick_s) begin
        case (state_r)
          IDLE: begin
            x_r      <= MID;
            en_enc_r <= 1'b0;
          end
          RUP: begin
            en_enc_r <= 1'b1;
            if (!i_mute && !empty_s) begin
              x_r <= step_toward(x_r, head_s);
            end
          end
          RUN: begin
            en_enc_r <= 1'b1;
            if (pop_s) begin
              x_r <= head_s;
            end
          end
          RDOWN: begin
            en_enc_r <= (x_r != MID);
            x_r      <= step_toward(x_r, MID);
          end
          default: begin
            x_r      <= MID;
            en_enc_r <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ef_smsdac8_seq.sv
// Self-checking bench for ef_smsdac8_seq: cycle table for ramp/mute, scoreboard for paced streams.
module tb_ef_smsdac8_seq;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [3:0] i_osr;
  logic       i_valid;
  logic [7:0] i_data;
  logic       o_ready;
  logic       i_mute;
  logic       i_dith_cfg;
  logic [7:0] o_x;
  logic       o_en_enc;
  logic       o_en_dith;
  logic       o_strobe;
  logic       o_underrun;

  ef_smsdac8_seq #(.DEPTH(4), .OSR_W(4)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_osr      (i_osr),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_ready    (o_ready),
    .i_mute     (i_mute),
    .i_dith_cfg (i_dith_cfg),
    .o_x        (o_x),
    .o_en_enc   (o_en_enc),
    .o_en_dith  (o_en_dith),
    .o_strobe   (o_strobe),
    .o_underrun (o_underrun)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       mute;
    logic [7:0] x;
    logic       strobe;
    logic       en;
    logic       dith;
    logic       und;
    logic       rdy;
  } vec_t;

  typedef struct {
    logic [7:0] x;
    logic       und;
    int         gap;
  } exp_t;

  vec_t tbl [16];
  exp_t exp_q [$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  int   strobe_cnt = 0;
  logic sb_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic expect_x(input logic [7:0] x, input logic und, input int gap);
    exp_t e;
    e.x = x;
    e.und = und;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic push_one(input logic [7:0] d);
    @(negedge i_clk);
    i_valid = 1'b1;
    i_data  = d;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_q_empty(input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      @(negedge i_clk);
      if (exp_q.size() == 0) return;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_strobe(input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      @(posedge i_clk);
      #1;
      if (o_strobe) return;
    end
    chk(name, 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    sb_en = 1'b0;
    exp_q.delete();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  // Scoreboard: every strobe pops one expected {o_x, o_underrun, spacing}
  always @(posedge i_clk) begin
    exp_t e;
    #1;
    cyc = cyc + 1;
    if (o_strobe) begin
      strobe_cnt = strobe_cnt + 1;
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_extra_strobe: got strobe with o_x=%0h, expected none", o_x);
        end else begin
          e = exp_q.pop_front();
          chk("sb_x", 32'(o_x), 32'(e.x));
          chk("sb_underrun", 32'(o_underrun), 32'(e.und));
          if (e.gap != 0) chk("sb_gap", 32'(cyc - last_cyc), 32'(e.gap));
        end
        last_cyc = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    //            valid  data   mute   x      strb  en    dith  und   rdy
    tbl[0]  = '{1'b1, 8'h84, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 8'h81, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 8'h82, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 8'h83, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 8'h84, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 8'h84, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 8'h83, 1'b0, 8'h84, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 8'hF0, 1'b0, 8'h83, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 8'h83, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 8'h82, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 8'h81, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 8'h55, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    i_rst = 1'b1;
    i_osr = 4'd0;
    i_valid = 1'b0;
    i_data = 8'h00;
    i_mute = 1'b0;
    i_dith_cfg = 1'b1;

    // Reset values
    @(posedge i_clk);
    #1;
    chk("rst_x", 32'(o_x), 32'h80);
    chk("rst_en_enc", 32'(o_en_enc), 32'd0);
    chk("rst_en_dith", 32'(o_en_dith), 32'd0);
    chk("rst_strobe", 32'(o_strobe), 32'd0);
    chk("rst_underrun", 32'(o_underrun), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Startup ramp, underrun, mute with data queued, flush (tick every cycle)
    for (int i = 0; i < 16; i++) begin
      @(negedge i_clk);
      i_valid = tbl[i].valid;
      i_data  = tbl[i].data;
      i_mute  = tbl[i].mute;
      @(posedge i_clk);
      #1;
      chk($sformatf("tbl%0d_x", i), 32'(o_x), 32'(tbl[i].x));
      chk($sformatf("tbl%0d_strobe", i), 32'(o_strobe), 32'(tbl[i].strobe));
      chk($sformatf("tbl%0d_en_enc", i), 32'(o_en_enc), 32'(tbl[i].en));
      chk($sformatf("tbl%0d_en_dith", i), 32'(o_en_dith), 32'(tbl[i].dith));
      chk($sformatf("tbl%0d_underrun", i), 32'(o_underrun), 32'(tbl[i].und));
      chk($sformatf("tbl%0d_ready", i), 32'(o_ready), 32'(tbl[i].rdy));
    end
    i_valid = 1'b0;
    i_mute = 1'b0;

    // Paced stream at osr=3: ramp to 8'h00, stream, underrun, resume, 8'hFF, mute ramp-down
    @(negedge i_clk);
    i_osr = 4'd3;
    i_dith_cfg = 1'b0;
    sb_en = 1'b1;
    for (int v = 127; v >= 0; v--) expect_x(8'(v), 1'b0, (v == 127) ? 0 : 4);
    expect_x(8'h00, 1'b0, 4);
    expect_x(8'h10, 1'b0, 4);
    expect_x(8'h20, 1'b0, 4);
    expect_x(8'h30, 1'b0, 4);
    for (int k = 0; k < 3; k++) expect_x(8'h30, 1'b1, 4);
    push_one(8'h00);
    push_one(8'h10);
    push_one(8'h20);
    push_one(8'h30);
    chk("b_full_ready", 32'(o_ready), 32'd0);
    wait_q_empty(1000, "b_ramp_timeout");
    chk("b_dith_off", 32'(o_en_dith), 32'd0);
    i_dith_cfg = 1'b1;
    @(posedge i_clk);
    #1;
    chk("b_dith_run", 32'(o_en_dith), 32'd1);
    expect_x(8'h40, 1'b0, 4);
    push_one(8'h40);
    wait_q_empty(100, "b_resume_timeout");
    expect_x(8'hFF, 1'b0, 4);
    push_one(8'hFF);
    push_one(8'h01);
    wait_q_empty(100, "b_ff_timeout");
    expect_x(8'hFF, 1'b0, 4);
    for (int v = 254; v >= 128; v--) expect_x(8'(v), 1'b0, 4);
    expect_x(8'h80, 1'b0, 4);
    i_mute = 1'b1;
    repeat (20) @(negedge i_clk);
    chk("b_ready_rdown", 32'(o_ready), 32'd0);
    i_mute = 1'b0;
    wait_q_empty(1000, "b_rdown_timeout");
    repeat (20) @(negedge i_clk);
    chk("b_idle_en_enc", 32'(o_en_enc), 32'd0);
    chk("b_idle_x", 32'(o_x), 32'h80);
    chk("b_idle_ready", 32'(o_ready), 32'd1);
    sb_en = 1'b0;

    // Reset mid-ramp
    i_osr = 4'd0;
    push_one(8'h90);
    repeat (4) @(posedge i_clk);
    #1;
    chk("c_pre_rst_x", 32'(o_x), 32'h83);
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    chk("c_rst_x", 32'(o_x), 32'h80);
    chk("c_rst_en_enc", 32'(o_en_enc), 32'd0);
    chk("c_rst_en_dith", 32'(o_en_dith), 32'd0);
    chk("c_rst_strobe", 32'(o_strobe), 32'd0);
    chk("c_rst_underrun", 32'(o_underrun), 32'd0);
    chk("c_rst_ready", 32'(o_ready), 32'd1);
    @(negedge i_clk);
    i_rst = 1'b0;
    strobe_cnt = 0;
    repeat (10) @(posedge i_clk);
    #1;
    chk("c_idle_strobes", 32'(strobe_cnt), 32'd0);
    chk("c_idle_en_enc", 32'(o_en_enc), 32'd0);
    chk("c_idle_x", 32'(o_x), 32'h80);

    // Full/backpressure at osr=15, same-cycle push and pop
    i_osr = 4'd15;
    do_reset();
    strobe_cnt = 0;
    sb_en = 1'b1;
    expect_x(8'h80, 1'b0, 0);
    expect_x(8'hA2, 1'b0, 16);
    expect_x(8'hA3, 1'b0, 16);
    expect_x(8'hA4, 1'b0, 16);
    expect_x(8'h55, 1'b0, 16);
    expect_x(8'h66, 1'b0, 16);
    expect_x(8'h77, 1'b0, 16);
    expect_x(8'h77, 1'b1, 16);
    push_one(8'h80);
    push_one(8'hA2);
    push_one(8'hA3);
    push_one(8'hA4);
    chk("d_full4_ready", 32'(o_ready), 32'd0);
    i_valid = 1'b1;
    i_data = 8'h55;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      if (o_ready) begin
        found = 1'b1;
        break;
      end
    end
    if (found) chk("d_ready_after_pop", 32'(strobe_cnt), 32'd1);
    else chk("d_ready_timeout", 32'd0, 32'd1);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    chk("d_full_again", 32'(o_ready), 32'd0);
    wait_strobe(40, "d_pop_timeout");
    repeat (15) @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b1;
    i_data = 8'h66;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    chk("d_push_pop_same", 32'(o_ready), 32'd1);
    @(negedge i_clk);
    i_valid = 1'b1;
    i_data = 8'h77;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    chk("d_full_after_77", 32'(o_ready), 32'd0);
    wait_q_empty(200, "d_drain_timeout");
    sb_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
